// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM
// states and the select/operation codes driven towards the datapath.
package mips_pkg;

  // Primary opcodes (instruction[31:26]) the controller understands
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Controller states; the numeric values are visible on the debug port
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EX   = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  // Operation request to the ALU control block
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // Second ALU operand select
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // True for every opcode that has an execution path in the FSM
  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS subset (R-type, lw, sw, beq, j,
// addi). Control outputs are decoded from the state register; only the
// memory-handshake dependent strobes and the illegal-opcode pulse also look
// at mem_ready / opcode in the cycle they are produced.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_reg;
  logic   ready;

  // Without the handshake every memory access completes in one cycle
  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = state_reg;

  // State register and next-state selection; opcode only matters in DECODE and MEM_ADR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:      state_reg <= S_FETCH;
        S_FETCH:     if (ready) state_reg <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:      state_reg <= S_EXECUTE;
            OP_LW, OP_SW:  state_reg <= S_MEM_ADR;
            OP_BEQ:        state_reg <= S_BRANCH;
            OP_J:          state_reg <= S_JUMP;
            OP_ADDI:       state_reg <= S_ADDI_EX;
            default:       state_reg <= S_FETCH;
          endcase
        end
        S_MEM_ADR:   state_reg <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (ready) state_reg <= S_MEM_WB;
        S_MEM_WB:    state_reg <= S_FETCH;
        S_MEM_WRITE: if (ready) state_reg <= S_FETCH;
        S_EXECUTE:   state_reg <= S_ALU_WB;
        S_ALU_WB:    state_reg <= S_FETCH;
        S_BRANCH:    state_reg <= S_FETCH;
        S_JUMP:      state_reg <= S_FETCH;
        S_ADDI_EX:   state_reg <= S_ADDI_WB;
        S_ADDI_WB:   state_reg <= S_FETCH;
        default:     state_reg <= S_FETCH;  // recover from unused encodings
      endcase
    end
  end

  // Output decode: everything low unless the current state asks for it
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_OP_ADD;
    pc_source     = PC_SRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        // IR and PC+4 commit only when the instruction word is actually there
        ir_write  = ready;
        pc_write  = ready;
      end
      S_DECODE: begin
        alu_src_b  = SRC_B_IMM_SH2;  // speculative branch target into ALUOut
        illegal_op = ~is_supported(opcode);
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_source     = PC_SRC_ALUOUT;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_source  = PC_SRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;  // IDLE and unused encodings keep every output low
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction step plan built
// from the instruction class predicts state and control outputs each cycle.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  typedef struct {
    int st;
    bit wait_rdy;
    bit illeg;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] opcode;
  logic       mem_ready;
  logic [5:0] opcode2;
  logic       mem_ready2;

  logic pw1, pwc1, iod1, mr1, mw1, irw1, m2r1, rd1, rw1, asa1, done1, ill1;
  logic [1:0] asb1, aop1, pcs1;
  logic [3:0] st1;
  logic pw2, pwc2, iod2, mr2, mw2, irw2, m2r2, rd2, rw2, asa2, done2, ill2;
  logic [1:0] asb2, aop2, pcs2;
  logic [3:0] st2;
  ctrl_t c1, c2;

  assign c1 = {pw1, pwc1, iod1, mr1, mw1, irw1, m2r1, rd1, rw1, asa1, asb1, aop1, pcs1, done1, ill1};
  assign c2 = {pw2, pwc2, iod2, mr2, mw2, irw2, m2r2, rd2, rw2, asa2, asb2, aop2, pcs2, done2, ill2};

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw1), .pc_write_cond(pwc1), .i_or_d(iod1), .mem_read(mr1),
    .mem_write(mw1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rd1),
    .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1),
    .pc_source(pcs1), .instr_done(done1), .illegal_op(ill1), .state(st1)
  );

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b0)) dut_nohs (
    .clk(clk), .rst(rst), .opcode(opcode2), .mem_ready(mem_ready2),
    .pc_write(pw2), .pc_write_cond(pwc2), .i_or_d(iod2), .mem_read(mr2),
    .mem_write(mw2), .ir_write(irw2), .mem_to_reg(m2r2), .reg_dst(rd2),
    .reg_write(rw2), .alu_src_a(asa2), .alu_src_b(asb2), .alu_op(aop2),
    .pc_source(pcs2), .instr_done(done2), .illegal_op(ill2), .state(st2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word each state must present, written from the output tables
  function automatic ctrl_t exp_ctrl(input int st, input bit rdy, input bit illeg);
    ctrl_t c = '0;
    case (st)
      1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      2:  begin c.alu_src_b = 2'b11; c.illegal_op = illeg; end
      3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4:  begin c.i_or_d = 1; c.mem_read = 1; end
      5:  begin c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; end
      6:  begin c.i_or_d = 1; c.mem_write = 1; c.instr_done = rdy; end
      7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      8:  begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
      9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_write_cond = 1; c.instr_done = 1; end
      10: begin c.pc_source = 2'b10; c.pc_write = 1; c.instr_done = 1; end
      11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      12: begin c.reg_write = 1; c.instr_done = 1; end
      default: ;
    endcase
    return c;
  endfunction

  step_t plan[$];

  // Instruction as a sequence of steps, starting at its FETCH
  task automatic load_instr(input logic [5:0] op);
    bit legal;
    legal = (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
    plan.push_back('{1, 1'b1, 1'b0});
    plan.push_back('{2, 1'b0, !legal});
    case (op)
      6'h00: begin plan.push_back('{7, 1'b0, 1'b0}); plan.push_back('{8, 1'b0, 1'b0}); end
      6'h23: begin plan.push_back('{3, 1'b0, 1'b0}); plan.push_back('{4, 1'b1, 1'b0}); plan.push_back('{5, 1'b0, 1'b0}); end
      6'h2B: begin plan.push_back('{3, 1'b0, 1'b0}); plan.push_back('{6, 1'b1, 1'b0}); end
      6'h04: plan.push_back('{9, 1'b0, 1'b0});
      6'h02: plan.push_back('{10, 1'b0, 1'b0});
      6'h08: begin plan.push_back('{11, 1'b0, 1'b0}); plan.push_back('{12, 1'b0, 1'b0}); end
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] ops [6];
    int         seq2 [6];
    logic [5:0] cur_op;
    step_t      s;
    int         since_rel;
    bit         injected;
    ops  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    seq2 = '{0, 1, 2, 3, 6, 1};
    cur_op     = 6'h00;
    injected   = 1'b0;
    opcode     = 6'h00;
    mem_ready  = 1'b0;
    opcode2    = 6'b101011;
    mem_ready2 = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_state", 32'(st1), 32'd0);
    check_val("reset_ctrl", 32'(c1), 32'd0);
    check_val("reset_state_nohs", 32'(st2), 32'd0);
    rst = 1'b0;
    plan.push_back('{0, 1'b0, 1'b0});
    since_rel = 0;

    for (int cyc = 0; cyc < 700; cyc++) begin
      s = plan[0];
      opcode    = (s.st == 2 || s.st == 3) ? cur_op : 6'($urandom);
      mem_ready = ($urandom_range(0, 2) != 0);
      #3;
      check_val("state", 32'(st1), 32'(s.st));
      check_val("ctrl", 32'(c1), 32'(exp_ctrl(s.st, mem_ready, s.illeg)));
      check_val("rd_wr_excl", 32'(mr1 & mw1), 32'd0);
      check_val("regw_memw_excl", 32'(rw1 & mw1), 32'd0);
      if (since_rel < 6) begin
        check_val("nohs_state", 32'(st2), 32'(seq2[since_rel]));
        check_val("nohs_ctrl", 32'(c2), 32'(exp_ctrl(seq2[since_rel], 1'b1, 1'b0)));
      end
      since_rel++;
      $display("cyc %0d op=%02h rdy=%0d state=%0d exp=%0d", cyc, opcode, mem_ready, st1, s.st);

      if (!injected && cyc > 150 && s.st == 4) begin
        // abort a load mid-access: reset must act without a clock edge
        injected = 1'b1;
        rst = 1'b1;
        #1;
        check_val("async_rst_state", 32'(st1), 32'd0);
        check_val("async_rst_ctrl", 32'(c1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        plan.delete();
        plan.push_back('{0, 1'b0, 1'b0});
        since_rel = 0;
        continue;
      end

      if (!(s.wait_rdy && !mem_ready)) void'(plan.pop_front());
      if (plan.size() == 0) begin
        int r;
        r = $urandom_range(0, 6);
        cur_op = (r == 6) ? 6'($urandom) : ops[r];
        load_instr(cur_op);
      end
      @(posedge clk);
      #1;
    end
    check_val("rst_injected", 32'(injected), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
